move_sequencer: RTL and testbench

- Sequences the 4x4 node array through one complete 2048 move.
- Accepts a one-hot direction request, launches the ready wave into the edge nodes and waits a fixed settle window.
- After the window it spawns a new tile through the array preset path, accumulates merges into a score, and flags win or game over.
- Sits between the button debouncer/top-level FSM and the node array.

---
 rtl/move_pkg.sv | 18 +
 rtl/move_sequencer_spawn_picker.sv | 27 ++
 rtl/move_sequencer.sv | 209 ++++++++++++++++++++
 tb/tb_move_sequencer.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/move_pkg.sv
// move_pkg: shared states, direction codes and helpers for the 2048 move sequencer.
package move_pkg;
  localparam int CELL_W = 4;
  localparam int N_CELLS = 16;
  localparam logic [3:0] DIR_UP = 4'b1000;
  localparam logic [3:0] DIR_DOWN = 4'b0100;
  localparam logic [3:0] DIR_LEFT = 4'b0010;
  localparam logic [3:0] DIR_RIGHT = 4'b0001;
  typedef enum logic [3:0] {
    IDLE, CLEAR, LAUNCH, SETTLE, COMPARE, SPAWN, SPAWN_WAIT, CHECK, DONE, OVER
  } state_e;
  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < 16; i++) n = n + {4'd0, v[i]};
    return n;
  endfunction
endpackage

// File: rtl/move_sequencer_spawn_picker.sv
// spawn_picker: picks the first empty cell at or above LFSR[3:0] (wrapping)
// and the tile code for a new spawn.
module spawn_picker
  import move_pkg::*;
(
  input  logic [63:0] grid_i,
  input  logic [7:0]  lfsr_i,
  output logic [3:0]  idx_o,
  output logic [3:0]  tile_o,
  output logic        none_empty_o
);
  logic [3:0] c;
  always_comb begin
    idx_o = '0;
    none_empty_o = 1'b1;
    c = '0;
    // descending scan so the nearest empty cell is the last one written
    for (int k = N_CELLS - 1; k >= 0; k--) begin
      c = lfsr_i[3:0] + 4'(k);
      if (grid_i[{c, 2'b00} +: CELL_W] == '0) begin
        idx_o = c;
        none_empty_o = 1'b0;
      end
    end
  end
  assign tile_o = (lfsr_i[7:4] == 4'h0) ? 4'h2 : 4'h1;
endmodule

// File: rtl/move_sequencer.sv
// move_sequencer: sequences the 4x4 node array through one 2048 move.
// Optional undo support is enabled with MOVE_SEQUENCER_UNDO_EN.
module move_sequencer
  import move_pkg::*;
#(
  parameter int SETTLE_CYCLES = 24,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter logic [3:0] WIN_VALUE = 4'hB
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [3:0]  dir_req_i,
  input  logic [63:0] grid_i,
  input  logic [31:0] node_movable_i,
  input  logic [15:0] node_score_i,
`ifdef MOVE_SEQUENCER_UNDO_EN
  input  logic        undo_req_i,
`endif
  output logic [3:0]  launch_o,
  output logic        preset_ext_o,
  output logic [63:0] preset_value_o,
  output logic        busy_o,
  output logic        move_done_o,
  output logic [15:0] score_o,
  output logic        win_o,
  output logic        game_over_o
);
  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  state_e state_q, state_d;
  logic [3:0] dir_q, dir_d;
  logic [63:0] snap_q, snap_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0] spawn_q, spawn_d;
  logic [15:0] score_q, score_d;
  logic win_q, win_d;
  logic [15:0] lfsr_q;
  logic [3:0] sp_idx, sp_tile;
  logic none_empty, any_win;
  logic [16:0] score_sum;
`ifdef MOVE_SEQUENCER_UNDO_EN
  logic [63:0] undo_q, undo_d;
  logic [15:0] undo_score_q, undo_score_d, pre_score_q, pre_score_d;
  logic undo_valid_q, undo_valid_d, undo_pend_q, undo_pend_d;
`endif

  spawn_picker u_pick (
    .grid_i      (grid_i),
    .lfsr_i      (lfsr_q[7:0]),
    .idx_o       (sp_idx),
    .tile_o      (sp_tile),
    .none_empty_o(none_empty)
  );

  assign score_sum = {1'b0, score_q} + {12'd0, popcount16(node_score_i)};

  always_comb begin
    any_win = 1'b0;
    for (int i = 0; i < N_CELLS; i++) any_win |= (grid_i[i*CELL_W +: CELL_W] == WIN_VALUE);
  end

  always_comb begin
    state_d = state_q;
    dir_d = dir_q;
    snap_d = snap_q;
    cnt_d = cnt_q;
    spawn_d = spawn_q;
    score_d = score_q;
    win_d = win_q;
    launch_o = '0;
    preset_ext_o = 1'b0;
    preset_value_o = '0;
    move_done_o = 1'b0;
`ifdef MOVE_SEQUENCER_UNDO_EN
    undo_d = undo_q;
    undo_score_d = undo_score_q;
    pre_score_d = pre_score_q;
    undo_valid_d = undo_valid_q;
    undo_pend_d = undo_pend_q;
`endif
    case (state_q)
      IDLE: begin
        if (start_i) state_d = CLEAR;
        else if ($onehot(dir_req_i)) begin
          dir_d = dir_req_i;
          snap_d = grid_i;
          state_d = LAUNCH;
`ifdef MOVE_SEQUENCER_UNDO_EN
          pre_score_d = score_q;
          undo_pend_d = 1'b0;
`endif
        end
`ifdef MOVE_SEQUENCER_UNDO_EN
        else if (undo_req_i && undo_valid_q) begin
          preset_ext_o = 1'b1;
          preset_value_o = undo_q;
          score_d = undo_score_q;
          undo_valid_d = 1'b0;
          move_done_o = 1'b1;
        end
`endif
      end
      CLEAR: begin
        preset_ext_o = 1'b1;
        score_d = '0;
        win_d = 1'b0;
        spawn_d = 2'd2;
        state_d = SPAWN;
`ifdef MOVE_SEQUENCER_UNDO_EN
        undo_valid_d = 1'b0;
`endif
      end
      LAUNCH: begin
        launch_o = dir_q;
        cnt_d = '0;
        state_d = SETTLE;
      end
      SETTLE: begin
        score_d = score_sum[16] ? 16'hFFFF : score_sum[15:0];
        cnt_d = cnt_q + 1'b1;
        state_d = (cnt_q == CW'(SETTLE_CYCLES - 1)) ? COMPARE : SETTLE;
      end
      COMPARE: begin
        if (grid_i == snap_q) state_d = DONE;
        else begin
          spawn_d = 2'd1;
          state_d = SPAWN;
`ifdef MOVE_SEQUENCER_UNDO_EN
          undo_pend_d = 1'b1;
`endif
        end
      end
      SPAWN: begin
        if (none_empty) spawn_d = '0;
        else begin
          preset_ext_o = 1'b1;
          preset_value_o = grid_i;
          preset_value_o[{sp_idx, 2'b00} +: CELL_W] = sp_tile;
          spawn_d = spawn_q - 2'd1;
        end
        state_d = SPAWN_WAIT;
      end
      SPAWN_WAIT: state_d = (spawn_q != '0) ? SPAWN : CHECK;
      CHECK: begin
        win_d = win_q | any_win;
        state_d = (none_empty && node_movable_i == '0) ? OVER : DONE;
      end
      DONE: begin
        move_done_o = 1'b1;
        state_d = IDLE;
`ifdef MOVE_SEQUENCER_UNDO_EN
        if (undo_pend_q) begin
          undo_d = snap_q;
          undo_score_d = pre_score_q;
          undo_valid_d = 1'b1;
          undo_pend_d = 1'b0;
        end
`endif
      end
      OVER: state_d = start_i ? CLEAR : OVER;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      dir_q <= '0;
      snap_q <= '0;
      cnt_q <= '0;
      spawn_q <= '0;
      score_q <= '0;
      win_q <= 1'b0;
      lfsr_q <= LFSR_SEED;
    end else begin
      state_q <= state_d;
      dir_q <= dir_d;
      snap_q <= snap_d;
      cnt_q <= cnt_d;
      spawn_q <= spawn_d;
      score_q <= score_d;
      win_q <= win_d;
      lfsr_q <= {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    end
  end

`ifdef MOVE_SEQUENCER_UNDO_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      undo_q <= '0;
      undo_score_q <= '0;
      pre_score_q <= '0;
      undo_valid_q <= 1'b0;
      undo_pend_q <= 1'b0;
    end else begin
      undo_q <= undo_d;
      undo_score_q <= undo_score_d;
      pre_score_q <= pre_score_d;
      undo_valid_q <= undo_valid_d;
      undo_pend_q <= undo_pend_d;
    end
  end
`endif

  assign busy_o = !(state_q inside {IDLE, OVER});
  assign game_over_o = (state_q == OVER);
  assign score_o = score_q;
  assign win_o = win_q;
endmodule

// File: tb/tb_move_sequencer.sv
// tb_move_sequencer: scoreboard bench; the bench also plays the node array,
// landing every preset into grid_i on the next clock.
module tb_move_sequencer;
  import move_pkg::*;
  localparam int K_LAUNCH = 0, K_CLEAR = 1, K_SPAWN = 2, K_DONE = 3;
  typedef struct {
    int kind;
    logic [63:0] val;
    int lat;
  } ev_t;

  logic clk = 1'b0, rst_ni = 1'b0, start_i = 1'b0;
  logic [3:0] dir_req_i = '0;
  logic [63:0] grid_i = '0;
  logic [31:0] node_movable_i = '0;
  logic [15:0] node_score_i = '0;
  logic [3:0] launch_o;
  logic preset_ext_o, busy_o, move_done_o, win_o, game_over_o;
  logic [63:0] preset_value_o;
  logic [15:0] score_o;
  logic [63:0] ovr_grid = '0;
  logic ovr_en = 1'b0;
  logic [15:0] m_lfsr;
  int tests = 0, fails = 0, cyc = 0, t_launch = 0, done_cnt = 0;
  ev_t q[$];

  move_sequencer dut (
    .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i), .dir_req_i(dir_req_i),
    .grid_i(grid_i), .node_movable_i(node_movable_i), .node_score_i(node_score_i),
`ifdef MOVE_SEQUENCER_UNDO_EN
    .undo_req_i(1'b0),
`endif
    .launch_o(launch_o), .preset_ext_o(preset_ext_o), .preset_value_o(preset_value_o),
    .busy_o(busy_o), .move_done_o(move_done_o), .score_o(score_o), .win_o(win_o),
    .game_over_o(game_over_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) grid_i <= ovr_en ? ovr_grid : (preset_ext_o ? preset_value_o : grid_i);
  // reference Fibonacci LFSR, taps 16,14,13,11
  always @(posedge clk or negedge rst_ni)
    if (!rst_ni) m_lfsr <= 16'hACE1;
    else m_lfsr <= {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] spawn_exp(input logic [63:0] g, input logic [15:0] l);
    logic [63:0] r;
    r = g;
    for (int k = 0; k < 16; k++) begin
      int c;
      c = (int'(l[3:0]) + k) % 16;
      if (g[c*4 +: 4] == 4'h0) begin
        r[c*4 +: 4] = (l[7:4] == 4'h0) ? 4'h2 : 4'h1;
        return r;
      end
    end
    return r;
  endfunction

  task automatic take(input int k, input string nm, output ev_t e, output bit ok);
    ok = 1'b0;
    if (q.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL unexpected_%s: got event want none", nm);
    end else begin
      e = q.pop_front();
      chk({nm, "_order"}, 64'(k), 64'(e.kind));
      ok = (e.kind == k);
    end
  endtask

  always @(negedge clk) begin
    ev_t e;
    bit ok;
    if (rst_ni) begin
      if (preset_ext_o && launch_o != '0) chk("preset_with_launch", 64'(launch_o), 64'd0);
      if (launch_o != '0) begin
        take(K_LAUNCH, "launch", e, ok);
        if (ok) chk("launch_dir", 64'(launch_o), e.val);
        t_launch = cyc;
      end
      if (preset_ext_o) begin
        if (q.size() != 0 && q[0].kind == K_CLEAR) begin
          take(K_CLEAR, "clear", e, ok);
          chk("clear_preset", preset_value_o, 64'd0);
        end else begin
          take(K_SPAWN, "spawn", e, ok);
          if (ok) chk("spawn_preset", preset_value_o, spawn_exp(grid_i, m_lfsr));
        end
      end
      if (move_done_o) begin
        take(K_DONE, "done", e, ok);
        if (ok) begin
          chk("done_score", 64'(score_o), 64'(e.val[15:0]));
          chk("done_win", 64'(win_o), 64'(e.val[16]));
          if (e.lat >= 0) chk("done_latency", 64'(cyc - t_launch), 64'(e.lat));
        end
        done_cnt++;
      end
    end
  end

  task automatic put_grid(input logic [63:0] v);
    ovr_grid = v;
    ovr_en = 1'b1;
    @(negedge clk);
    ovr_en = 1'b0;
  endtask

  task automatic exp_ev(input int k, input logic [63:0] v, input int lat);
    q.push_back('{k, v, lat});
  endtask

  task automatic exp_done(input int s, input bit w, input int lat);
    q.push_back('{K_DONE, {47'd0, w, 16'(s)}, lat});
  endtask

  task automatic wait_done(input int n);
    for (int i = 0; i < 200 && done_cnt < n; i++) @(negedge clk);
    if (done_cnt < n) begin
      tests++;
      fails++;
      $display("FAIL done_timeout: got %0d done pulses want %0d", done_cnt, n);
    end
    @(negedge clk);
  endtask

  task automatic move(input logic [3:0] d);
    dir_req_i = d;
    @(negedge clk);
    dir_req_i = '0;
    repeat (3) @(negedge clk);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_launch"}, 64'(launch_o), 64'd0);
    chk({nm, "_preset"}, 64'(preset_ext_o), 64'd0);
    chk({nm, "_pvalue"}, preset_value_o, 64'd0);
    chk({nm, "_busy"}, 64'(busy_o), 64'd0);
    chk({nm, "_done"}, 64'(move_done_o), 64'd0);
    chk({nm, "_score"}, 64'(score_o), 64'd0);
    chk({nm, "_win"}, 64'(win_o), 64'd0);
    chk({nm, "_over"}, 64'(game_over_o), 64'd0);
  endtask

  initial begin
    int nz;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst_ni = 1'b1;
    @(negedge clk);
    // new game: clear then two spawns
    exp_ev(K_CLEAR, 64'd0, -1);
    exp_ev(K_SPAWN, 64'd0, -1);
    exp_ev(K_SPAWN, 64'd0, -1);
    exp_done(0, 1'b0, -1);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    wait_done(1);
    nz = 0;
    for (int i = 0; i < 16; i++) nz += (grid_i[i*4 +: 4] inside {4'h1, 4'h2}) ? 1 : 0;
    chk("start_tiles", 64'(nz), 64'd2);
    // legal left move with one merge; a stray dir during SETTLE must be dropped
    node_movable_i = '1;
    put_grid(64'h11);
    exp_ev(K_LAUNCH, 64'(DIR_LEFT), -1);
    exp_ev(K_SPAWN, 64'd0, -1);
    exp_done(1, 1'b0, 29);
    move(DIR_LEFT);
    chk("settle_busy", 64'(busy_o), 64'd1);
    dir_req_i = DIR_UP;
    node_score_i = 16'h0001;
    put_grid(64'h2);
    node_score_i = '0;
    dir_req_i = '0;
    wait_done(2);
    // illegal move: grid unchanged, no spawn
    exp_ev(K_LAUNCH, 64'(DIR_RIGHT), -1);
    exp_done(1, 1'b0, 26);
    move(DIR_RIGHT);
    wait_done(3);
    // multi-hot request ignored
    dir_req_i = 4'b0110;
    repeat (3) @(negedge clk);
    dir_req_i = '0;
    chk("multihot_busy", 64'(busy_o), 64'd0);
    // merge into 2048 sets win
    put_grid(64'hAA);
    exp_ev(K_LAUNCH, 64'(DIR_LEFT), -1);
    exp_ev(K_SPAWN, 64'd0, -1);
    exp_done(2, 1'b1, 29);
    move(DIR_LEFT);
    node_score_i = 16'h0002;
    put_grid(64'hB);
    node_score_i = '0;
    wait_done(4);
    // win stays set on a later move
    exp_ev(K_LAUNCH, 64'(DIR_DOWN), -1);
    exp_done(2, 1'b1, 26);
    move(DIR_DOWN);
    wait_done(5);
    // full board, nothing movable: no spawn, game over
    node_movable_i = '0;
    put_grid(64'h2121_2121_2121_2121);
    exp_ev(K_LAUNCH, 64'(DIR_UP), -1);
    move(DIR_UP);
    put_grid(64'h2121_2121_2121_2123);
    for (int i = 0; i < 100 && !game_over_o; i++) @(negedge clk);
    chk("over_reached", 64'(game_over_o), 64'd1);
    chk("over_busy", 64'(busy_o), 64'd0);
    chk("over_score", 64'(score_o), 64'd2);
    chk("over_win", 64'(win_o), 64'd1);
    dir_req_i = DIR_LEFT;
    repeat (3) @(negedge clk);
    dir_req_i = '0;
    chk("over_hold", 64'(game_over_o), 64'd1);
    // restart from OVER clears everything
    exp_ev(K_CLEAR, 64'd0, -1);
    exp_ev(K_SPAWN, 64'd0, -1);
    exp_ev(K_SPAWN, 64'd0, -1);
    exp_done(0, 1'b0, -1);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    chk("restart_over", 64'(game_over_o), 64'd0);
    wait_done(6);
    // async reset in the middle of SETTLE
    node_movable_i = '1;
    put_grid(64'h0000_0000_0000_0101);
    exp_ev(K_LAUNCH, 64'(DIR_RIGHT), -1);
    move(DIR_RIGHT);
    node_score_i = 16'h0007;
    @(negedge clk);
    node_score_i = '0;
    repeat (2) @(negedge clk);
    chk("pre_rst_score", 64'(score_o), 64'd3);
    #2 rst_ni = 1'b0;
    #1 chk_zero("midreset");
    @(posedge clk);
    #2 rst_ni = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_busy", 64'(busy_o), 64'd0);
    chk("queue_empty", 64'(q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
